// File: rtl/rfm_cnt_ctrl_if.sv
// Bundle of the ACT/RFM request channels, the victim hand-off channel,
// status flags and the cnt_cam access bus around rfm_cnt_ctrl.
interface rfm_cnt_ctrl_if #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned ENTRY_WIDTH = 7
);
  logic                   act_valid;
  logic                   act_ready;
  logic [ENTRY_WIDTH-1:0] act_entry;
  logic                   rfm_valid;
  logic                   rfm_ready;
  logic                   rfm_done;
  logic                   mit_valid;
  logic                   mit_ready;
  logic [ENTRY_WIDTH-1:0] mit_entry;
  logic [WORD_SIZE-1:0]   mit_count;
  logic                   clr_all;
  logic                   alert;
  logic                   err;
  logic [WORD_SIZE-1:0]   cam_data_in;
  logic [ENTRY_WIDTH-1:0] cam_addr_in;
  logic                   cam_read_en;
  logic                   cam_write_en;
  logic                   cam_search_en;
  logic                   cam_reset;
  logic [WORD_SIZE-1:0]   cam_data_out;
  logic [ENTRY_WIDTH-1:0] cam_addr_out;
  logic                   cam_match;
  logic [WORD_SIZE-1:0]   cam_max;

  // Controller side.
  modport master (
    input  act_valid, act_entry, rfm_valid, mit_ready, clr_all,
    input  cam_data_out, cam_addr_out, cam_match, cam_max,
    output act_ready, rfm_ready, rfm_done, mit_valid, mit_entry, mit_count,
    output alert, err,
    output cam_data_in, cam_addr_in, cam_read_en, cam_write_en, cam_search_en, cam_reset
  );

  // Requesters, mitigation engine and CAM side.
  modport slave (
    output act_valid, act_entry, rfm_valid, mit_ready, clr_all,
    output cam_data_out, cam_addr_out, cam_match, cam_max,
    input  act_ready, rfm_ready, rfm_done, mit_valid, mit_entry, mit_count,
    input  alert, err,
    input  cam_data_in, cam_addr_in, cam_read_en, cam_write_en, cam_search_en, cam_reset
  );
endinterface

// File: rtl/rfm_cnt_ctrl.sv
// Sequencer for the activation-counter CAM: read-modify-write increment per
// ACT, max-entry search / hand-off / zeroing per RFM, threshold alert, clears.
module rfm_cnt_ctrl #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned ENTRY_WIDTH = 7,
  parameter int unsigned ROW_NUM     = 68,
  parameter int unsigned THRESHOLD   = 512
) (
  input logic          clk,
  input logic          rstn,
  rfm_cnt_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StInit, StIdle, StActRd, StActWr, StMitSrch, StMitOut, StMitClr, StMitDone
  } state_e;

  // One extra bit so parameter values at the edge of the field compare cleanly.
  localparam logic [ENTRY_WIDTH:0] RowLimit   = (ENTRY_WIDTH+1)'(ROW_NUM);
  localparam logic [WORD_SIZE:0]   AlertLevel = (WORD_SIZE+1)'(THRESHOLD);

  state_e                 state_q, state_d;
  logic [ENTRY_WIDTH-1:0] entry_q, entry_d;
  logic [WORD_SIZE-1:0]   cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   max_q, max_d;
  logic                   err_q, err_d;
  logic                   alert_q;
  logic                   act_in_range;

  assign act_in_range  = ({1'b0, bus.act_entry} < RowLimit);
  assign bus.mit_entry = entry_q;
  assign bus.mit_count = max_q;
  assign bus.alert     = alert_q;
  assign bus.err       = err_q;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StInit;
      entry_q <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      err_q   <= err_d;
      alert_q <= ({1'b0, bus.cam_max} >= AlertLevel);
    end
  end

  // Next-state, handshakes and CAM strobes decoded from the current state.
  always_comb begin
    state_d           = state_q;
    entry_d           = entry_q;
    cnt_d             = cnt_q;
    max_d             = max_q;
    err_d             = err_q;
    bus.act_ready     = 1'b0;
    bus.rfm_ready     = 1'b0;
    bus.rfm_done      = 1'b0;
    bus.mit_valid     = 1'b0;
    bus.cam_data_in   = '0;
    bus.cam_addr_in   = '0;
    bus.cam_read_en   = 1'b0;
    bus.cam_write_en  = 1'b0;
    bus.cam_search_en = 1'b0;
    bus.cam_reset     = 1'b0;
    unique case (state_q)
      StInit: begin
        bus.cam_reset = 1'b1;
        state_d       = StIdle;
      end
      StIdle: begin
        if (bus.clr_all) begin
          state_d = StInit;
        end else if (bus.rfm_valid) begin
          bus.rfm_ready = 1'b1;
          max_d         = bus.cam_max;
          state_d       = StMitSrch;
        end else begin
          bus.act_ready = 1'b1;
          if (bus.act_valid) begin
            entry_d = bus.act_entry;
            // Out-of-range entries are accepted and dropped.
            if (act_in_range) state_d = StActRd;
          end
        end
      end
      StActRd: begin
        bus.cam_read_en = 1'b1;
        bus.cam_addr_in = entry_q;
        cnt_d           = bus.cam_data_out;
        state_d         = StActWr;
      end
      StActWr: begin
        bus.cam_write_en = 1'b1;
        bus.cam_addr_in  = entry_q;
        bus.cam_data_in  = (&cnt_q) ? cnt_q : cnt_q + WORD_SIZE'(1);
        state_d          = StIdle;
      end
      StMitSrch: begin
        if (max_q == '0) begin
          // Nothing to mitigate: skip the search entirely.
          state_d = StMitDone;
        end else begin
          bus.cam_search_en = 1'b1;
          bus.cam_data_in   = max_q;
          if (bus.cam_match) begin
            entry_d = bus.cam_addr_out;
            state_d = StMitOut;
          end else begin
            err_d   = 1'b1;
            state_d = StMitDone;
          end
        end
      end
      StMitOut: begin
        bus.mit_valid = 1'b1;
        if (bus.mit_ready) state_d = StMitClr;
      end
      StMitClr: begin
        bus.cam_write_en = 1'b1;
        bus.cam_addr_in  = entry_q;
        state_d          = StMitDone;
      end
      StMitDone: begin
        bus.rfm_done = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

endmodule

// File: tb/tb_rfm_cnt_ctrl.sv
// Bench for rfm_cnt_ctrl: behavioural CAM, transaction-level counter model,
// table-driven ACT vectors, hand-written corner sequences, random traffic.
module tb_rfm_cnt_ctrl;
  localparam int WS = 16;
  localparam int EW = 7;
  localparam int RN = 68;
  localparam int TH = 512;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  rfm_cnt_ctrl_if #(.WORD_SIZE(WS), .ENTRY_WIDTH(EW)) bus ();

  rfm_cnt_ctrl #(
    .WORD_SIZE(WS), .ENTRY_WIDTH(EW), .ROW_NUM(RN), .THRESHOLD(TH)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Behavioural CAM.
  logic [WS-1:0] mem [RN];
  logic          pre_en = 1'b0;
  int            pre_idx = 0;
  int            pre_val = 0;
  logic          force_max = 1'b0;
  logic [WS-1:0] force_val = '0;
  logic          force_nomatch = 1'b0;

  always_comb begin
    logic [WS-1:0] mx;
    bus.cam_data_out = (int'(bus.cam_addr_in) < RN) ? mem[bus.cam_addr_in] : '0;
    mx = '0;
    for (int i = 0; i < RN; i++) if (mem[i] > mx) mx = mem[i];
    bus.cam_max = force_max ? force_val : mx;
    bus.cam_match = 1'b0;
    bus.cam_addr_out = '0;
    for (int i = RN - 1; i >= 0; i--) begin
      if (mem[i] == bus.cam_data_in) begin
        bus.cam_match = 1'b1;
        bus.cam_addr_out = EW'(i);
      end
    end
    if (force_nomatch) bus.cam_match = 1'b0;
  end

  always @(posedge clk) begin
    if (bus.cam_reset) begin
      for (int i = 0; i < RN; i++) mem[i] <= '0;
    end else if (bus.cam_write_en && int'(bus.cam_addr_in) < RN) begin
      mem[bus.cam_addr_in] <= bus.cam_data_in;
    end
    if (pre_en) mem[pre_idx] <= WS'(pre_val);
  end

  // Reference model of the counters.
  int exp_cnt [RN];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < RN; i++) exp_cnt[i] = 0;
  endtask

  task automatic preload(input int idx, input int val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    exp_cnt[idx] = val;
  endtask

  // Observations from the last ACT.
  int a_rd, a_wr, a_wdata, a_waddr;

  task automatic do_act(input int e);
    bit got;
    got = 0; a_rd = 0; a_wr = 0; a_wdata = -1; a_waddr = -1;
    bus.act_entry = EW'(e);
    bus.act_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.act_ready) got = 1;
    end
    chk("act_accept", int'(got), 1);
    @(posedge clk); #1;
    bus.act_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.cam_read_en) a_rd = 1;
      if (bus.cam_write_en) begin
        a_wr = 1;
        a_wdata = int'(bus.cam_data_in);
        a_waddr = int'(bus.cam_addr_in);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic act_and_check(input string tag, input int e);
    int want;
    int inr;
    inr  = (e < RN) ? 1 : 0;
    want = (e < RN) ? sat_inc(exp_cnt[e]) : 0;
    do_act(e);
    chk({tag, "_rd"}, a_rd, inr);
    chk({tag, "_wr"}, a_wr, inr);
    if (e < RN) begin
      chk({tag, "_wdata"}, a_wdata, want);
      chk({tag, "_waddr"}, a_waddr, e);
      exp_cnt[e] = want;
      chk({tag, "_mem"}, int'(mem[e]), want);
    end
  endtask

  // Observations from the last RFM.
  int r_srch, r_sdata, r_mit, r_ment, r_mcnt, r_stable, r_wr, r_waddr, r_wdata;
  int r_done_c, r_done_n;

  task automatic do_rfm(input int hold);
    bit got;
    got = 0; r_srch = 0; r_sdata = -1; r_mit = 0; r_ment = -1; r_mcnt = -1;
    r_stable = 1; r_wr = 0; r_waddr = -1; r_wdata = -1; r_done_c = -1; r_done_n = 0;
    bus.rfm_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.rfm_ready) got = 1;
    end
    chk("rfm_accept", int'(got), 1);
    @(posedge clk); #1;
    bus.rfm_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.cam_search_en) begin
        r_srch++;
        r_sdata = int'(bus.cam_data_in);
      end
      if (bus.mit_valid) begin
        r_mit++;
        if (r_mit == 1) begin
          r_ment = int'(bus.mit_entry);
          r_mcnt = int'(bus.mit_count);
        end else if (int'(bus.mit_entry) != r_ment || int'(bus.mit_count) != r_mcnt) begin
          r_stable = 0;
        end
        bus.mit_ready = (r_mit >= hold);
      end else begin
        bus.mit_ready = 1'b0;
      end
      if (bus.cam_write_en) begin
        r_wr++;
        r_waddr = int'(bus.cam_addr_in);
        r_wdata = int'(bus.cam_data_in);
      end
      if (bus.rfm_done) begin
        r_done_n++;
        if (r_done_c < 0) r_done_c = c;
      end
      if (r_done_c >= 0 && c > r_done_c) break;
    end
    bus.mit_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rfm_and_check(input string tag, input int hold);
    int mx, vic, vexp;
    mx = 0; vic = -1;
    for (int i = 0; i < RN; i++) begin
      if (exp_cnt[i] > mx) begin
        mx = exp_cnt[i];
        vic = i;
      end
    end
    vexp = (hold < 1) ? 1 : hold;
    do_rfm(hold);
    chk({tag, "_done_n"}, r_done_n, 1);
    if (mx == 0) begin
      chk({tag, "_srch"}, r_srch, 0);
      chk({tag, "_mit"}, r_mit, 0);
      chk({tag, "_wr"}, r_wr, 0);
      chk({tag, "_done_c"}, r_done_c, 1);
    end else begin
      chk({tag, "_srch"}, r_srch, 1);
      chk({tag, "_sdata"}, r_sdata, mx);
      chk({tag, "_mit"}, r_mit, vexp);
      chk({tag, "_ment"}, r_ment, vic);
      chk({tag, "_mcnt"}, r_mcnt, mx);
      chk({tag, "_stable"}, r_stable, 1);
      chk({tag, "_waddr"}, r_waddr, vic);
      chk({tag, "_wdata"}, r_wdata, 0);
      chk({tag, "_done_c"}, r_done_c, vexp + 2);
      exp_cnt[vic] = 0;
      chk({tag, "_mem"}, int'(mem[vic]), 0);
    end
  endtask

  typedef struct {
    int entry;
    int pre;    // -1: no preload
    int acc;    // CAM access expected
    int wdata;
  } act_vec_t;

  act_vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_c [$];
    int wd [$];
    int bad, mm;
    bus.act_valid = 1'b0; bus.act_entry = '0; bus.rfm_valid = 1'b0;
    bus.mit_ready = 1'b0; bus.clr_all = 1'b0;

    tbl[0] = '{entry: 9,   pre: 'hFFFF, acc: 1, wdata: 'hFFFF};
    tbl[1] = '{entry: 70,  pre: -1,     acc: 0, wdata: 0};
    tbl[2] = '{entry: 68,  pre: -1,     acc: 0, wdata: 0};
    tbl[3] = '{entry: 67,  pre: 100,    acc: 1, wdata: 101};
    tbl[4] = '{entry: 0,   pre: 0,      acc: 1, wdata: 1};
    tbl[5] = '{entry: 127, pre: -1,     acc: 0, wdata: 0};
    tbl[6] = '{entry: 9,   pre: 'hFFFE, acc: 1, wdata: 'hFFFF};

    // Reset and INIT pulse.
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("rst_cam_reset", int'(bus.cam_reset), 1);
    chk("rst_act_ready", int'(bus.act_ready), 0);
    chk("rst_cam_write", int'(bus.cam_write_en), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("init_cam_reset", int'(bus.cam_reset), 1);
    @(negedge clk);
    chk("idle_cam_reset", int'(bus.cam_reset), 0);
    chk("idle_act_ready", int'(bus.act_ready), 1);
    chk("idle_rfm_ready", int'(bus.rfm_ready), 0);
    chk("idle_alert", int'(bus.alert), 0);
    chk("idle_err", int'(bus.err), 0);
    chk("idle_mit_valid", int'(bus.mit_valid), 0);
    model_clear();
    @(posedge clk); #1;

    // Back-to-back ACT on entry 5 with valid held.
    bus.act_entry = EW'(5);
    bus.act_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.act_valid && bus.act_ready) acc_c.push_back(c);
      if (bus.cam_write_en) wd.push_back(int'(bus.cam_data_in));
      @(posedge clk); #1;
      if (acc_c.size() == 3) bus.act_valid = 1'b0;
    end
    chk("b2b_accepts", acc_c.size(), 3);
    chk("b2b_gap1", (acc_c.size() > 1) ? acc_c[1] - acc_c[0] : -1, 3);
    chk("b2b_gap2", (acc_c.size() > 2) ? acc_c[2] - acc_c[1] : -1, 3);
    chk("b2b_wd0", (wd.size() > 0) ? wd[0] : -1, 1);
    chk("b2b_wd1", (wd.size() > 1) ? wd[1] : -1, 2);
    chk("b2b_wd2", (wd.size() > 2) ? wd[2] : -1, 3);
    chk("b2b_mem5", int'(mem[5]), 3);
    exp_cnt[5] = 3;

    // Table of single ACTs: saturation and range boundaries.
    foreach (tbl[i]) begin
      if (tbl[i].pre >= 0) preload(tbl[i].entry, tbl[i].pre);
      do_act(tbl[i].entry);
      chk($sformatf("tbl%0d_rd", i), a_rd, tbl[i].acc);
      chk($sformatf("tbl%0d_wr", i), a_wr, tbl[i].acc);
      if (tbl[i].acc != 0) begin
        chk($sformatf("tbl%0d_wdata", i), a_wdata, tbl[i].wdata);
        exp_cnt[tbl[i].entry] = tbl[i].wdata;
      end
    end

    // clr_all beats a simultaneous ACT.
    bus.clr_all = 1'b1;
    bus.act_entry = EW'(5);
    bus.act_valid = 1'b1;
    @(negedge clk);
    chk("clr_act_ready", int'(bus.act_ready), 0);
    chk("clr_rfm_ready", int'(bus.rfm_ready), 0);
    @(posedge clk); #1;
    bus.clr_all = 1'b0;
    bus.act_valid = 1'b0;
    @(negedge clk);
    chk("clr_cam_reset", int'(bus.cam_reset), 1);
    chk("clr_no_read", int'(bus.cam_read_en), 0);
    @(negedge clk);
    chk("clr_cam_reset_off", int'(bus.cam_reset), 0);
    chk("clr_mem5", int'(mem[5]), 0);
    model_clear();
    @(posedge clk); #1;

    // RFM with all counters zero.
    rfm_and_check("rfm_zero", 2);
    chk("rfm_zero_err", int'(bus.err), 0);

    // RFM with 3=7, 40=12 and mit_ready held low.
    preload(3, 7);
    preload(40, 12);
    rfm_and_check("rfm_40", 4);
    chk("rfm_40_keep3", int'(mem[3]), 7);

    // Search miss sets a sticky err.
    force_nomatch = 1'b1;
    preload(2, 5);
    do_rfm(1);
    force_nomatch = 1'b0;
    chk("miss_srch", r_srch, 1);
    chk("miss_sdata", r_sdata, 7);
    chk("miss_mit", r_mit, 0);
    chk("miss_done_c", r_done_c, 1);
    chk("miss_err", int'(bus.err), 1);
    act_and_check("miss_act", 2);
    chk("miss_err_sticky", int'(bus.err), 1);

    // Reset in the middle of an ACT: no late write, err cleared.
    bus.act_entry = EW'(2);
    bus.act_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.act_valid = 1'b0;
    @(negedge clk);
    chk("midrst_read", int'(bus.cam_read_en), 1);
    rstn = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.cam_write_en || !bus.cam_reset) bad++;
    end
    chk("midrst_no_write", bad, 0);
    chk("midrst_err", int'(bus.err), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_mem2", int'(mem[2]), 0);
    model_clear();
    @(posedge clk); #1;

    // Alert threshold with one-cycle lag.
    force_max = 1'b1;
    force_val = WS'(511);
    @(posedge clk); #1;
    chk("alert_511", int'(bus.alert), 0);
    force_val = WS'(512);
    @(negedge clk);
    chk("alert_lag", int'(bus.alert), 0);
    @(posedge clk); #1;
    chk("alert_512", int'(bus.alert), 1);
    force_max = 1'b0;
    @(posedge clk); #1;
    chk("alert_clear", int'(bus.alert), 0);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8) act_and_check("rnd_act", int'($urandom_range(0, 75)));
      else rfm_and_check("rnd_rfm", int'($urandom_range(0, 3)));
    end

    mm = 0;
    for (int i = 0; i < RN; i++) if (int'(mem[i]) != exp_cnt[i]) mm++;
    chk("final_array", mm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
